// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered result/zero flag.
// Arithmetic and logic ops finish in one cycle; shifts iterate 1 bit per cycle.
// A valid/ready handshake on both sides lets the pipeline stall around shifts.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request, in_ready=1
// SHIFT | iterative shift in progress, one bit per cycle
// DONE  | result/zero held with out_valid=1 until out_ready
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic [XLEN-1:0]    op_a,
    input  logic [XLEN-1:0]    op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic               zero,
    output logic               busy
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          ctrl_q;
    logic [XLEN-1:0]     work_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [XLEN-1:0]     result_q;
    logic                zero_q;

    logic [XLEN-1:0]     alu_d;
    logic [XLEN-1:0]     shift_d;
    logic                is_shift;
    logic [SHAMT_W-1:0]  shamt;

    assign shamt    = op_b[SHAMT_W-1:0];
    assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

    // Single-cycle arithmetic/logic result from the live request operands.
    always_comb begin
        alu_d = op_a + op_b;
        case (alu_ctrl)
            OP_SUB:  alu_d = op_a - op_b;
            OP_SLT:  alu_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_d = op_a ^ op_b;
            OP_OR:   alu_d = op_a | op_b;
            OP_AND:  alu_d = op_a & op_b;
            default: alu_d = op_a + op_b;
        endcase
    end

    // One-bit step of the iterative shifter, direction taken from the captured op.
    always_comb begin
        shift_d = {work_q[XLEN-1], work_q[XLEN-1:1]};
        case (ctrl_q)
            OP_SLL:  shift_d = {work_q[XLEN-2:0], 1'b0};
            OP_SRL:  shift_d = {1'b0, work_q[XLEN-1:1]};
            default: shift_d = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    // Control FSM with registered result, zero flag, work register and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ctrl_q   <= OP_ADD;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ctrl_q <= alu_ctrl;
                        if (is_shift) begin
                            work_q <= op_a;
                            cnt_q  <= shamt;
                            if (shamt == '0) begin
                                result_q <= op_a;
                                zero_q   <= (op_a == '0);
                                state_q  <= DONE;
                            end else begin
                                state_q  <= SHIFT;
                            end
                        end else begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == '0);
                            state_q  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q <= shift_d;
                        zero_q   <= (shift_d == '0);
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized checks of alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural reference: the op-code table evaluated with plain operators.
    function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (c)
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0101: return a >> sh;
            4'b1101: return 32'($signed(a) >>> sh);
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
        if (c == 4'b0001 || c == 4'b0101 || c == 4'b1101) return 1 + int'(b % 32);
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // Present one request for exactly one accept edge, then scramble the inputs.
    task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
    endtask

    // Count cycles from C+1 until out_valid, then check latency and outputs.
    task automatic finish_op(input string tag, input logic [31:0] exp_res, input int exp_lat);
        int lat = 1;
        while (out_valid !== 1'b1 && lat <= 40) begin
            check({tag, "_busy_shift"}, {31'd0, busy}, 32'd1);
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consume_out_valid", {31'd0, out_valid}, 32'd0);
        check("consume_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
        start_op(c, a, b);
        finish_op(tag, model_res(c, a, b), model_lat(c, b));
        consume();
    endtask

    initial begin
        logic [31:0] held_res;
        logic        held_zero;
        logic [3:0]  rc;
        logic [31:0] ra, rb;

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed: wrap, compares, zero flag
        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("sub", 4'b1000, 32'd5, 32'd7);
        run_op("slt", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("xor_eq", 4'b0100, 32'hA5A5_1234, 32'hA5A5_1234);
        check("const_add_wrap", model_res(4'b0000, 32'hFFFF_FFFF, 32'd1), 32'h0);

        // Directed: shift latency and fill
        run_op("sra4", 4'b1101, 32'h8000_0000, 32'h0000_0024);
        run_op("srl4", 4'b0101, 32'h8000_0000, 32'h0000_0024);
        run_op("sll31", 4'b0001, 32'h0000_0001, 32'd31);
        run_op("sll0", 4'b0001, 32'h0000_1234, 32'h0000_0020);

        // Back-pressure: DONE holds for 10 cycles while new requests are offered
        start_op(4'b0110, 32'h00F0_0000, 32'h0000_000F);
        finish_op("bp", 32'h00F0_000F, 1);
        held_res = result; held_zero = zero;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; alu_ctrl = 4'b0000; op_a = $urandom; op_b = $urandom;
            @(posedge clk); #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, 32'h00F0_000F);
            check("bp_zero", {31'd0, zero}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        consume();
        run_op("after_bp_and", 4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0);

        // Asynchronous reset in the middle of SRA by 20, after the 7th shift
        start_op(4'b1101, 32'h8000_0001, 32'd20);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        run_op("post_rst_add", 4'b0000, 32'd2, 32'd3);
        run_op("undef_1111", 4'b1111, 32'd2, 32'd3);

        // Randomized ops with random consumer delay
        for (int i = 0; i < 40; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'd0 : $urandom;
            start_op(rc, ra, rb);
            finish_op("rand", model_res(rc, ra, rb), model_lat(rc, rb));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                check("rand_hold", result, model_res(rc, ra, rb));
            end
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
